// File: rtl/ext_stage_if.sv
// Handshake bundle between decode, the extension stage and the ALU operand mux.
// The slave modport is the stage's view; the master modport is the surrounding pipeline's view.
interface ext_stage_if #(
   parameter int DATA_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_instr;
   logic [DATA_W-1:0] in_rs_data;
   logic [2:0]        in_mode;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_err;

   modport master (
      output in_valid, in_instr, in_rs_data, in_mode, out_ready,
      input  in_ready, out_valid, out_data, out_err
   );

   modport slave (
      input  in_valid, in_instr, in_rs_data, in_mode, out_ready,
      output in_ready, out_valid, out_data, out_err
   );
endinterface

// File: rtl/ext_stage.sv
// Registered immediate/shift-amount extension stage: extends the selected instruction field
// at push time and buffers results in a 2-entry FIFO with valid/ready on both sides.
module ext_stage #(
   parameter int DATA_W    = 32,
   parameter int IMM_W     = 16,
   parameter int SHAMT_W   = 5,
   parameter int SHAMT_LSB = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   ext_stage_if.slave  bus
);

   typedef enum logic [2:0] {
      MODE_ZERO      = 3'b000,
      MODE_SIGN      = 3'b001,
      MODE_UPPER     = 3'b010,
      MODE_SHAMT     = 3'b011,
      MODE_SHAMT_VAR = 3'b100,
      MODE_BRANCH    = 3'b101,
      MODE_RSV6      = 3'b110,
      MODE_RSV7      = 3'b111
   } mode_e;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              err;
   } entry_t;

   logic [IMM_W-1:0]  imm;
   logic [DATA_W-1:0] sext_imm;
   entry_t            ext_d;

   assign imm      = bus.in_instr[IMM_W-1:0];
   assign sext_imm = DATA_W'($signed(imm));

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      ext_d = '0;
      case (mode_e'(bus.in_mode))
         MODE_ZERO:      ext_d.data = DATA_W'(imm);
         MODE_SIGN:      ext_d.data = sext_imm;
         MODE_UPPER:     ext_d.data = {imm, {(DATA_W-IMM_W){1'b0}}};
         MODE_SHAMT:     ext_d.data = DATA_W'(bus.in_instr[SHAMT_LSB +: SHAMT_W]);
         MODE_SHAMT_VAR: ext_d.data = DATA_W'(bus.in_rs_data[SHAMT_W-1:0]);
         MODE_BRANCH:    ext_d.data = sext_imm << 2;
         default:        ext_d.err  = 1'b1;
      endcase
   end

   entry_t     mem_q [2];
   logic       rd_ptr_q;
   logic       wr_ptr_q;
   logic [1:0] count_q;
   logic [1:0] count_d;
   logic       push;
   logic       pop;

   // in_ready depends only on registered occupancy, never on out_ready.
   assign bus.in_ready  = (count_q != 2'd2);
   assign bus.out_valid = (count_q != 2'd0);
   assign bus.out_data  = mem_q[rd_ptr_q].data;
   assign bus.out_err   = mem_q[rd_ptr_q].err;

   assign push = bus.in_valid  & bus.in_ready;
   assign pop  = bus.out_valid & bus.out_ready;

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q  <= 2'd0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         // NOTE: storage is cleared on reset (not on flush) so the head reads 0 right after reset.
         mem_q[0] <= '0;
         mem_q[1] <= '0;
      end else if (flush) begin
         count_q  <= 2'd0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
      end else begin
         count_q <= count_d;
         if (push) begin
            mem_q[wr_ptr_q] <= ext_d;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
      end
   end

endmodule
